router_b_seq: RTL and testbench

- Micro-op sequencer for the router_b operand router in the Kalman filter datapath.
- Accepts one arithmetic micro-op at a time over a valid/ready handshake and decodes it into the router control fields (sel_R, sel_S, inv_R, inv_S, sel_I).
- Holds those fields stable for the downstream adder latency, then pulses a result-write strobe with the destination and tag.
- ABS uses a two-pass probe of the router's R sign bit (msb_R).

---
 rtl/router_b_pkg.sv | 43 ++++
 rtl/router_b_decode.sv | 37 +++
 rtl/router_b_seq.sv | 143 ++++++++++++++
 tb/tb_router_b_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_b_pkg.sv
// Shared encodings and types for the router_b micro-op sequencer.
package router_b_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_RSUB = 4'd3;
    localparam logic [3:0] OP_MOVA = 4'd4;
    localparam logic [3:0] OP_MOVB = 4'd5;
    localparam logic [3:0] OP_INC  = 4'd6;
    localparam logic [3:0] OP_DEC  = 4'd7;
    localparam logic [3:0] OP_ACCQ = 4'd8;
    localparam logic [3:0] OP_ACCD = 4'd9;
    localparam logic [3:0] OP_NEGB = 4'd10;
    localparam logic [3:0] OP_ABSA = 4'd11;

    localparam logic [1:0] SELR_A    = 2'b00;
    localparam logic [1:0] SELR_RQ   = 2'b01;
    localparam logic [1:0] SELR_ZERO = 2'b10;
    localparam logic [1:0] SELR_ONES = 2'b11;
    localparam logic [1:0] SELS_B    = 2'b00;
    localparam logic [1:0] SELS_RD   = 2'b01;
    localparam logic [1:0] SELS_ZERO = 2'b10;
    localparam logic [1:0] SELS_ONES = 2'b11;
    localparam logic [1:0] IMM_ZERO  = 2'b00;
    localparam logic [1:0] IMM_P1    = 2'b01;
    localparam logic [1:0] IMM_M1    = 2'b10;

    typedef enum logic [2:0] {ST_IDLE, ST_PROBE, ST_ISSUE, ST_WAIT, ST_WB} state_e;

    typedef struct packed {
        logic [1:0] sel_R;
        logic [1:0] sel_S;
        logic       inv_R;
        logic       inv_S;
        logic [1:0] sel_I;
    } rcfg_t;

    // Parked config routes 0 + 0 + 0; the probe config exposes raw A on R.
    localparam rcfg_t CFG_PARK  = {SELR_ZERO, SELS_ZERO, 1'b0, 1'b0, IMM_ZERO};
    localparam rcfg_t CFG_PROBE = {SELR_A, SELS_ZERO, 1'b0, 1'b0, IMM_ZERO};

endpackage

// File: rtl/router_b_decode.sv
// Combinational opcode -> router config map; ABSA resolves on the probed sign.
module router_b_decode
    import router_b_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic       msb_r_i,
    output rcfg_t      cfg_o,
    output logic       illegal_o,
    output logic       is_abs_o
);

    always_comb begin
        cfg_o     = CFG_PARK;
        illegal_o = 1'b0;
        is_abs_o  = 1'b0;
        case (op_i)
            OP_NOP:  cfg_o = CFG_PARK;
            OP_ADD:  cfg_o = {SELR_A,    SELS_B,    1'b0, 1'b0, IMM_ZERO};
            OP_SUB:  cfg_o = {SELR_A,    SELS_B,    1'b0, 1'b1, IMM_P1};
            OP_RSUB: cfg_o = {SELR_A,    SELS_B,    1'b1, 1'b0, IMM_P1};
            OP_MOVA: cfg_o = {SELR_A,    SELS_ZERO, 1'b0, 1'b0, IMM_ZERO};
            OP_MOVB: cfg_o = {SELR_ZERO, SELS_B,    1'b0, 1'b0, IMM_ZERO};
            OP_INC:  cfg_o = {SELR_A,    SELS_ZERO, 1'b0, 1'b0, IMM_P1};
            OP_DEC:  cfg_o = {SELR_A,    SELS_ZERO, 1'b0, 1'b0, IMM_M1};
            OP_ACCQ: cfg_o = {SELR_RQ,   SELS_B,    1'b0, 1'b0, IMM_ZERO};
            OP_ACCD: cfg_o = {SELR_A,    SELS_RD,   1'b0, 1'b0, IMM_ZERO};
            OP_NEGB: cfg_o = {SELR_ZERO, SELS_B,    1'b0, 1'b1, IMM_P1};
            OP_ABSA: begin
                is_abs_o = 1'b1;
                cfg_o    = msb_r_i ? rcfg_t'({SELR_A, SELS_ZERO, 1'b1, 1'b0, IMM_P1})
                                   : rcfg_t'({SELR_A, SELS_ZERO, 1'b0, 1'b0, IMM_ZERO});
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/router_b_seq.sv
// Micro-op sequencer: accepts one op, holds router config across the adder
// latency, then strobes the write-back with destination and tag.
module router_b_seq
    import router_b_pkg::*;
#(
    parameter int ALU_LAT = 2,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic             in_dst,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             msb_R,
    output logic [1:0]       sel_R,
    output logic [1:0]       sel_S,
    output logic             inv_R,
    output logic             inv_S,
    output logic [1:0]       sel_I,
    output logic             alu_en,
    output logic             res_wr,
    output logic             res_dst,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy,
    output logic             op_err
);

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    rcfg_t            cfg_q, cfg_d;
    logic [3:0]       op_q, op_d;
    logic             dst_q, dst_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             err_q, err_d;
    logic             alu_en_q, res_wr_q;

    logic [3:0] dec_op;
    rcfg_t      dec_cfg;
    logic       dec_illegal, dec_abs;

    // Outside IDLE the only pending decode is the ABSA issue after its probe.
    assign dec_op = (state_q == ST_IDLE) ? in_op : op_q;

    router_b_decode u_dec (
        .op_i      (dec_op),
        .msb_r_i   (msb_R),
        .cfg_o     (dec_cfg),
        .illegal_o (dec_illegal),
        .is_abs_o  (dec_abs)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cfg_d   = cfg_q;
        op_d    = op_q;
        dst_d   = dst_q;
        tag_d   = tag_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d  = in_op;
                    dst_d = in_dst;
                    tag_d = in_tag;
                    if (dec_illegal) begin
                        err_d = 1'b1;
                    end else if (dec_abs) begin
                        state_d = ST_PROBE;
                        cfg_d   = CFG_PROBE;
                    end else if (in_op != OP_NOP) begin
                        state_d = ST_ISSUE;
                        cfg_d   = dec_cfg;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            ST_PROBE: begin
                state_d = ST_ISSUE;
                cfg_d   = dec_cfg;
                cnt_d   = LAT_M1;
            end
            ST_ISSUE, ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_WB;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = ST_WAIT;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
                cfg_d   = CFG_PARK;
            end
            default: begin
                state_d = ST_IDLE;
                cfg_d   = CFG_PARK;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cfg_q    <= CFG_PARK;
            op_q     <= OP_NOP;
            dst_q    <= 1'b0;
            tag_q    <= '0;
            err_q    <= 1'b0;
            alu_en_q <= 1'b0;
            res_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cfg_q    <= cfg_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            tag_q    <= tag_d;
            err_q    <= err_d;
            alu_en_q <= (state_d == ST_ISSUE);
            res_wr_q <= (state_d == ST_WB);
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign sel_R    = cfg_q.sel_R;
    assign sel_S    = cfg_q.sel_S;
    assign inv_R    = cfg_q.inv_R;
    assign inv_S    = cfg_q.inv_S;
    assign sel_I    = cfg_q.sel_I;
    assign alu_en   = alu_en_q;
    assign res_wr   = res_wr_q;
    assign res_dst  = dst_q;
    assign res_tag  = tag_q;
    assign op_err   = err_q;

endmodule

// File: tb/tb_router_b_seq.sv
// Directed bench for router_b_seq with a 24-bit router/adder model on its outputs.
module tb_router_b_seq;
    import router_b_pkg::*;

    localparam int LAT = 2;
    localparam int TW  = 4;
    localparam logic [23:0] RQV = 24'h000100;
    localparam logic [23:0] RDV = 24'h000010;
    localparam logic [23:0] BV  = 24'hABCDEF;
    localparam logic [7:0]  PARK = 8'b10_10_0_0_00;

    logic          clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_dst = 1'b0;
    logic [3:0]    in_op = 4'd0;
    logic [TW-1:0] in_tag = '0;
    logic          in_ready, msb_R, inv_R, inv_S, alu_en, res_wr, res_dst, busy, op_err;
    logic [1:0]    sel_R, sel_S, sel_I;
    logic [TW-1:0] res_tag;
    logic [23:0]   a_v = 24'h123456;
    logic [23:0]   r_now;

    int n_pass = 0, n_tot = 0;

    always #5 clk = ~clk;

    router_b_seq #(.ALU_LAT(LAT), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_dst(in_dst), .in_tag(in_tag), .msb_R(msb_R),
        .sel_R(sel_R), .sel_S(sel_S), .inv_R(inv_R), .inv_S(inv_S), .sel_I(sel_I),
        .alu_en(alu_en), .res_wr(res_wr), .res_dst(res_dst), .res_tag(res_tag),
        .busy(busy), .op_err(op_err)
    );

    function automatic logic [23:0] rpath(input logic [1:0] sr, input logic ir, input logic [23:0] a);
        logic [23:0] r;
        case (sr)
            2'b00:   r = a;
            2'b01:   r = RQV;
            2'b10:   r = 24'h0;
            default: r = 24'hFFFFFF;
        endcase
        return ir ? ~r : r;
    endfunction

    function automatic logic [23:0] route(input logic [7:0] c, input logic [23:0] a);
        logic [23:0] s, i;
        case (c[5:4])
            2'b00:   s = BV;
            2'b01:   s = RDV;
            2'b10:   s = 24'h0;
            default: s = 24'hFFFFFF;
        endcase
        if (c[2]) s = ~s;
        case (c[1:0])
            2'b01:   i = 24'h1;
            2'b10:   i = 24'hFFFFFF;
            default: i = 24'h0;
        endcase
        return rpath(c[7:6], c[3], a) + s + i;
    endfunction

    assign r_now = rpath(sel_R, inv_R, a_v);
    assign msb_R = r_now[23];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic        dst;
        logic [3:0]  tag;
        logic [23:0] a;
        logic [7:0]  cfg;
        logic [23:0] res;
    } vec_t;

    vec_t v[12];

    task automatic run_op(input vec_t t, input string nm);
        int k_alu, k_wr, exp_alu;
        logic [7:0] cfg_a, cfg_now;
        logic stable;
        logic [23:0] res;
        k_alu = -1; k_wr = -1; stable = 1'b1; cfg_a = '0; res = '0;
        exp_alu = (t.op == OP_ABSA) ? 2 : 1;
        @(negedge clk);
        a_v = t.a; in_op = t.op; in_dst = t.dst; in_tag = t.tag; in_valid = 1'b1;
        chk($sformatf("%s.ready", nm), in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 1; k <= 20 && k_wr < 0; k++) begin
            cfg_now = {sel_R, sel_S, inv_R, inv_S, sel_I};
            if (k == 1 && t.op == OP_ABSA)
                chk($sformatf("%s.probe", nm), {alu_en, cfg_now}, {1'b0, 8'b00_10_0_0_00});
            if (alu_en && k_alu < 0) begin
                k_alu = k; cfg_a = cfg_now; res = route(cfg_now, t.a);
            end else if (k_alu > 0 && cfg_now !== cfg_a) begin
                stable = 1'b0;
            end
            if (res_wr) begin
                k_wr = k;
                chk($sformatf("%s.dst", nm), res_dst, t.dst);
                chk($sformatf("%s.tag", nm), res_tag, t.tag);
            end
            @(negedge clk);
        end
        chk($sformatf("%s.alu_cyc", nm), k_alu, exp_alu);
        chk($sformatf("%s.wr_lat", nm), k_wr - k_alu, LAT);
        chk($sformatf("%s.cfg", nm), cfg_a, t.cfg);
        chk($sformatf("%s.result", nm), res, t.res);
        chk($sformatf("%s.stable", nm), stable, 1);
        chk($sformatf("%s.idle", nm), {in_ready, busy, res_wr, sel_R, sel_S}, {3'b100, 4'b1010});
    endtask

    logic [3:0] bop[3];
    logic [3:0] btag[3];
    int wr_c[4];
    logic [3:0] wr_t[4];

    initial begin
        logic seen, open, stable, accept;
        logic [7:0] cfg_a, cfg_now;
        int idx, nwr;

        v[0]  = '{OP_ADD,  1'b0, 4'd1,  24'h123456, 8'b00_00_0_0_00, 24'hBE0245};
        v[1]  = '{OP_SUB,  1'b1, 4'd5,  24'h123456, 8'b00_00_0_1_01, 24'h666667};
        v[2]  = '{OP_RSUB, 1'b0, 4'd2,  24'h123456, 8'b00_00_1_0_01, 24'h999999};
        v[3]  = '{OP_MOVA, 1'b1, 4'd3,  24'h123456, 8'b00_10_0_0_00, 24'h123456};
        v[4]  = '{OP_MOVB, 1'b0, 4'd4,  24'h123456, 8'b10_00_0_0_00, 24'hABCDEF};
        v[5]  = '{OP_INC,  1'b1, 4'd6,  24'h123456, 8'b00_10_0_0_01, 24'h123457};
        v[6]  = '{OP_DEC,  1'b0, 4'd7,  24'h123456, 8'b00_10_0_0_10, 24'h123455};
        v[7]  = '{OP_ACCQ, 1'b1, 4'd8,  24'h123456, 8'b01_00_0_0_00, 24'hABCEEF};
        v[8]  = '{OP_ACCD, 1'b0, 4'd9,  24'h123456, 8'b00_01_0_0_00, 24'h123466};
        v[9]  = '{OP_NEGB, 1'b1, 4'd10, 24'h123456, 8'b10_00_0_1_01, 24'h543211};
        v[10] = '{OP_ABSA, 1'b1, 4'd11, 24'hC0FFEE, 8'b00_10_1_0_01, 24'h3F0012};
        v[11] = '{OP_ABSA, 1'b0, 4'd12, 24'h123456, 8'b00_10_0_0_00, 24'h123456};

        // Reset and idle
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst.cfg", {sel_R, sel_S, inv_R, inv_S, sel_I}, PARK);
        chk("rst.ready_busy", {in_ready, busy}, 2'b10);
        chk("rst.strobes", {alu_en, res_wr, op_err}, 3'b000);
        chk("rst.dst_tag", {res_dst, res_tag}, 5'd0);

        for (int i = 0; i < 12; i++) run_op(v[i], $sformatf("vec%0d", i));

        // Illegal opcode
        @(negedge clk);
        in_op = 4'd13; in_tag = 4'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ill.err", {op_err, alu_en, res_wr}, 3'b100);
        chk("ill.ready", {in_ready, busy}, 2'b10);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (op_err || alu_en || res_wr) seen = 1'b1;
        end
        chk("ill.quiet", seen, 0);

        // Reset while an ACCQ sits in WAIT
        @(negedge clk);
        a_v = 24'h123456; in_op = OP_ACCQ; in_dst = 1'b1; in_tag = 4'd9; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("arst.pre_busy", {busy, alu_en, sel_R}, {2'b10, 2'b01});
        #1 rst = 1'b1;
        #1;
        chk("arst.cfg", {sel_R, sel_S, inv_R, inv_S, sel_I}, PARK);
        chk("arst.state", {in_ready, busy, alu_en, res_wr}, 4'b1000);
        chk("arst.dst_tag", {res_dst, res_tag}, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (res_wr || alu_en) seen = 1'b1;
        end
        chk("arst.no_wr", seen, 0);
        run_op(v[0], "post_rst");

        // Back-to-back ADD, DEC, NOP with in_valid held high
        bop[0] = OP_ADD; btag[0] = 4'd1;
        bop[1] = OP_DEC; btag[1] = 4'd2;
        bop[2] = OP_NOP; btag[2] = 4'd3;
        idx = 0; nwr = 0; open = 1'b0; stable = 1'b1; cfg_a = '0;
        for (int j = 0; j < 4; j++) begin wr_c[j] = -1; wr_t[j] = '0; end
        @(negedge clk);
        for (int c = 0; c < 30; c++) begin
            cfg_now = {sel_R, sel_S, inv_R, inv_S, sel_I};
            if (alu_en) begin
                open = 1'b1; cfg_a = cfg_now;
            end else if (open && cfg_now !== cfg_a) begin
                stable = 1'b0;
            end
            if (res_wr) begin
                if (nwr < 4) begin wr_c[nwr] = c; wr_t[nwr] = res_tag; end
                nwr++;
                open = 1'b0;
            end
            if (idx < 3) begin
                in_op = bop[idx]; in_tag = btag[idx]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            accept = in_valid && in_ready;
            @(posedge clk);
            if (accept) idx++;
            @(negedge clk);
        end
        chk("b2b.accepted", idx, 3);
        chk("b2b.nwr", nwr, 2);
        chk("b2b.spacing", wr_c[1] - wr_c[0], LAT + 2);
        chk("b2b.tags", {wr_t[0], wr_t[1]}, {4'd1, 4'd2});
        chk("b2b.stable", stable, 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
